// File: rtl/dual_alu_io_responder.sv
// -----------------------------------------------------------------------------
// dual_alu_io_responder
// Pad-side responder for the dual 4-bit ALU interface. The operand/select word
// on io_in[37:18] is synchronised, debounced until it has been stable for
// STABLE_CYCLES samples, latched, and then evaluated by two small ALUs. The
// 15-bit result word (two 5-bit lane results, a 4-bit sequence count and a
// valid flag) is driven onto io_out[17:4] and io_out[0].
//
// Parameters
//   SYNC_STAGES    flops in the pad-input synchroniser (>= 2)
//   STABLE_CYCLES  equal consecutive samples required to accept a word (1..255)
//
// Ports
//   wb_clk_i      in   clock, rising edge
//   wb_rst_i      in   asynchronous active-high reset
//   io_in[37:0]   in   pads: [21:18]=A0 [25:22]=B0 [29:26]=A1 [33:30]=B1
//                            [35:34]=SEL0 [37:36]=SEL1; other bits ignored
//   io_out[37:0]  out  R[0] on bit 0, R[14:1] on bits 17:4, all others 0
//   io_oeb[37:0]  out  active-low output enables for the driven bits
//   result_valid  out  R[14], set by the first accepted word
//   busy          out  high while the controller is settling or updating
// -----------------------------------------------------------------------------
module dual_alu_io_responder #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [37:0] io_in,
  output logic [37:0] io_out,
  output logic [37:0] io_oeb,
  output logic        result_valid,
  output logic        busy
);

  localparam int unsigned IO_W   = 38;
  localparam int unsigned WORD_W = 20;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned SEQ_W  = 4;
  localparam int unsigned LANE_W = 5;
  localparam int unsigned RES_W  = 15;

  // Enables for the run state: bit 0 and bits 17:4 driven, everything else input.
  localparam logic [IO_W-1:0]  OEB_RUN    = 38'h3F_FFFC_000E;
  localparam logic [CNT_W-1:0] STABLE_TGT = CNT_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    UPDATE = 2'd2
  } state_e;

  // Pad-input synchroniser; the last stage is the word seen by the controller.
  logic [SYNC_STAGES-1:0][WORD_W-1:0] sync_q;
  logic [WORD_W-1:0]                  word;

  state_e             state_q;
  logic [CNT_W-1:0]   stable_cnt_q;
  logic [WORD_W-1:0]  word_prev_q;
  logic [WORD_W-1:0]  acc_q;
  logic               first_q;
  logic [SEQ_W-1:0]   seq_q;
  logic [RES_W-1:0]   r_q;
  logic               busy_q;
  logic [IO_W-1:0]    oeb_q;

  logic [LANE_W-1:0]  y0;
  logic [LANE_W-1:0]  y1;
  logic [SEQ_W-1:0]   seq_d;

  // Pad bits outside the operand field carry nothing for this block.
  logic unused_io;
  assign unused_io = ^io_in[17:0];

  // One ALU lane: add with carry, subtract with borrow, AND, XOR.
  function automatic logic [LANE_W-1:0] alu_lane(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [1:0] sel
  );
    logic [LANE_W-1:0] y;
    case (sel)
      2'b00:   y = {1'b0, a} + {1'b0, b};
      2'b01:   y = {1'b0, a} - {1'b0, b};
      2'b10:   y = {1'b0, a & b};
      default: y = {1'b0, a ^ b};
    endcase
    return y;
  endfunction

  // Synchroniser shift chain.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], io_in[37:18]};
    end
  end

  assign word = sync_q[SYNC_STAGES-1];

  // Lane results are always taken from the accepted word, never the live pads.
  assign y0    = alu_lane(acc_q[3:0],  acc_q[7:4],   acc_q[17:16]);
  assign y1    = alu_lane(acc_q[11:8], acc_q[15:12], acc_q[19:18]);
  assign seq_d = seq_q + SEQ_W'(1);

  // Controller: debounce, accept, and publish the result word.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      stable_cnt_q <= '0;
      word_prev_q  <= '0;
      acc_q        <= '0;
      first_q      <= 1'b1;
      seq_q        <= '0;
      r_q          <= '0;
      busy_q       <= 1'b0;
      oeb_q        <= '1;
    end else begin
      oeb_q       <= OEB_RUN;
      word_prev_q <= word;
      case (state_q)
        IDLE: begin
          // After reset the first settled word is always published.
          if ((word != acc_q) || first_q) begin
            state_q      <= SETTLE;
            stable_cnt_q <= CNT_W'(1);
            busy_q       <= 1'b1;
          end
        end
        SETTLE: begin
          if (word != word_prev_q) begin
            stable_cnt_q <= CNT_W'(1);
          end else if (stable_cnt_q >= STABLE_TGT) begin
            // A word that settled back onto the accepted value is not republished.
            if ((word == acc_q) && !first_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= UPDATE;
              acc_q   <= word;
            end
          end else begin
            stable_cnt_q <= stable_cnt_q + CNT_W'(1);
          end
        end
        UPDATE: begin
          r_q     <= {1'b1, seq_d, y1, y0};
          seq_q   <= seq_d;
          first_q <= 1'b0;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign io_out       = {20'b0, r_q[14:1], 3'b0, r_q[0]};
  assign io_oeb       = oeb_q;
  assign result_valid = r_q[14];
  assign busy         = busy_q;

endmodule

// File: tb/tb_dual_alu_io_responder.sv
// -----------------------------------------------------------------------------
// tb_dual_alu_io_responder
// Self-checking bench for dual_alu_io_responder. Expected result words come
// from a small arithmetic model of the two ALU lanes, a modulo-16 sequence
// counter and the documented pad mapping and latency.
// -----------------------------------------------------------------------------
module tb_dual_alu_io_responder;

  localparam int unsigned SYNC_STAGES   = 2;
  localparam int unsigned STABLE_CYCLES = 8;
  // Ticks from driving the pads until the edge that publishes the result.
  localparam int LAT_TICKS = SYNC_STAGES + STABLE_CYCLES + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [37:0] io_in;
  logic [37:0] io_out;
  logic [37:0] io_oeb;
  logic        result_valid;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  int          model_seq;
  logic [19:0] model_acc;
  logic [37:0] model_out;
  logic [37:0] oeb_run;

  dual_alu_io_responder #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .io_in       (io_in),
    .io_out      (io_out),
    .io_oeb      (io_oeb),
    .result_valid(result_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int lane(input int a, input int b, input int sel);
    case (sel)
      0:       return (a + b) % 32;
      1:       return (a - b + 32) % 32;
      2:       return a & b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [14:0] result(input logic [19:0] w, input int seq);
    int a0, b0, a1, b1, s0, s1, r;
    a0 = int'(w) % 16;
    b0 = (int'(w) / 16) % 16;
    a1 = (int'(w) / 256) % 16;
    b1 = (int'(w) / 4096) % 16;
    s0 = (int'(w) / 65536) % 4;
    s1 = (int'(w) / 262144) % 4;
    r  = 16384 + seq * 1024 + lane(a1, b1, s1) * 32 + lane(a0, b0, s0);
    return 15'(r);
  endfunction

  function automatic logic [37:0] pads(input logic [14:0] r);
    logic [37:0] o;
    o    = '0;
    o[0] = r[0];
    for (int k = 1; k < 15; k++) o[k + 3] = r[k];
    return o;
  endfunction

  function automatic logic [19:0] mkword(input int a0, input int b0, input int s0,
                                         input int a1, input int b1, input int s1);
    return 20'(a0 + b0 * 16 + a1 * 256 + b1 * 4096 + s0 * 65536 + s1 * 262144);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    io_in[17:0] = 18'($urandom);
  endtask

  task automatic drive(input logic [19:0] w);
    io_in = {w, 18'($urandom)};
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(mkword(9, 9, 0, 0, 0, 0));
    repeat (3) tick();
    compared++;
    if (io_out !== 38'h0) begin
      mismatched++;
      $display("FAIL reset_io_out: got %h expected %h", io_out, 38'h0);
    end
    compared++;
    if (io_oeb !== {38{1'b1}}) begin
      mismatched++;
      $display("FAIL reset_io_oeb: got %h expected %h", io_oeb, {38{1'b1}});
    end
    compared++;
    if (result_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_valid: got %b expected 0", result_valid);
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    rst = 1'b0;
    tick();
    compared++;
    if (io_oeb !== oeb_run) begin
      mismatched++;
      $display("FAIL release_io_oeb: got %h expected %h", io_oeb, oeb_run);
    end
    compared++;
    if (io_out !== 38'h0) begin
      mismatched++;
      $display("FAIL release_io_out: got %h expected %h", io_out, 38'h0);
    end
    model_seq = 0;
    model_out = '0;
  endtask

  task automatic test_first_word();
    logic [19:0] w;
    int          n;
    w = mkword(9, 9, 0, 0, 0, 0);
    n = 0;
    while (result_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    model_seq = 1;
    model_acc = w;
    model_out = pads(result(w, model_seq));
    compared++;
    if (result_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL first_word_timeout: valid=%b after %0d cycles expected 1", result_valid, n);
    end
    compared++;
    if (io_out !== model_out) begin
      mismatched++;
      $display("FAIL first_word_value: got %h expected %h", io_out, model_out);
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL first_word_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_second_word();
    logic [19:0] w;
    logic [37:0] exp;
    int          early;
    logic        busy_upd;
    w         = mkword(3, 5, 1, 12, 10, 3);
    model_seq = (model_seq + 1) % 16;
    exp       = pads(result(w, model_seq));
    early     = 0;
    busy_upd  = 1'b0;
    drive(w);
    for (int c = 1; c <= LAT_TICKS; c++) begin
      tick();
      if (c < LAT_TICKS && io_out !== model_out) early++;
      if (c == LAT_TICKS - 1) busy_upd = busy;
    end
    compared++;
    if (early != 0) begin
      mismatched++;
      $display("FAIL second_word_early: %0d early changes expected 0", early);
    end
    compared++;
    if (io_out !== exp) begin
      mismatched++;
      $display("FAIL second_word_value: got %h expected %h", io_out, exp);
    end
    compared++;
    if (busy_upd !== 1'b1) begin
      mismatched++;
      $display("FAIL second_word_busy: got %b expected 1", busy_upd);
    end
    model_out = exp;
    model_acc = w;
  endtask

  task automatic test_glitch();
    int   changes;
    logic busy_seen;
    changes   = 0;
    busy_seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(model_acc ^ 20'(1 + ($urandom % 15)));
      tick();
      if (io_out !== model_out) changes++;
      if (busy === 1'b1) busy_seen = 1'b1;
    end
    drive(model_acc);
    for (int c = 0; c < 40; c++) begin
      tick();
      if (io_out !== model_out) changes++;
      if (busy === 1'b1) busy_seen = 1'b1;
    end
    compared++;
    if (changes != 0) begin
      mismatched++;
      $display("FAIL glitch_no_update: %0d cycles with io_out != %h", changes, model_out);
    end
    compared++;
    if (busy_seen !== 1'b1) begin
      mismatched++;
      $display("FAIL glitch_busy_pulse: got %b expected 1", busy_seen);
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL glitch_busy_end: got %b expected 0", busy);
    end
    compared++;
    if (int'(io_out[16:13]) != model_seq) begin
      mismatched++;
      $display("FAIL glitch_seq: got %0d expected %0d", io_out[16:13], model_seq);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] used[$];
    logic [19:0] w;
    logic [37:0] exp;
    int          early;
    bit          dup;
    for (int n = 0; n < 16; n++) begin
      do begin
        w   = 20'($urandom);
        dup = (w == model_acc);
        foreach (used[i]) if (used[i] == w) dup = 1'b1;
      end while (dup);
      used.push_back(w);
      model_seq = (model_seq + 1) % 16;
      exp       = pads(result(w, model_seq));
      early     = 0;
      drive(w);
      for (int c = 1; c <= LAT_TICKS; c++) begin
        tick();
        if (c < LAT_TICKS && io_out !== model_out) early++;
      end
      compared++;
      if (early != 0) begin
        mismatched++;
        $display("FAIL b2b_early[%0d]: %0d early changes expected 0", n, early);
      end
      compared++;
      if (io_out !== exp) begin
        mismatched++;
        $display("FAIL b2b_value[%0d]: got %h expected %h", n, io_out, exp);
      end
      compared++;
      if (result_valid !== 1'b1) begin
        mismatched++;
        $display("FAIL b2b_valid[%0d] seq=%0d: got %b expected 1", n, model_seq, result_valid);
      end
      model_out = exp;
      model_acc = w;
    end
  endtask

  task automatic test_reset_mid_settle();
    logic [19:0] w;
    int          n;
    do w = 20'($urandom); while (w == model_acc);
    drive(w);
    repeat (4) tick();
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_settle_busy: got %b expected 1", busy);
    end
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (io_out !== 38'h0) begin
      mismatched++;
      $display("FAIL async_reset_io_out: got %h expected %h", io_out, 38'h0);
    end
    compared++;
    if (io_oeb !== {38{1'b1}}) begin
      mismatched++;
      $display("FAIL async_reset_io_oeb: got %h expected %h", io_oeb, {38{1'b1}});
    end
    compared++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset_flags: got valid=%b busy=%b expected 0 0", result_valid, busy);
    end
    repeat (2) tick();
    rst = 1'b0;
    n   = 0;
    while (result_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    model_seq = 1;
    model_acc = w;
    model_out = pads(result(w, model_seq));
    compared++;
    if (io_out !== model_out) begin
      mismatched++;
      $display("FAIL post_reset_value: got %h expected %h after %0d cycles", io_out, model_out, n);
    end
    compared++;
    if (io_oeb !== oeb_run) begin
      mismatched++;
      $display("FAIL post_reset_io_oeb: got %h expected %h", io_oeb, oeb_run);
    end
  endtask

  initial begin
    for (int i = 0; i < 38; i++) oeb_run[i] = !((i == 0) || (i >= 4 && i <= 17));
    model_seq = 0;
    model_acc = '0;
    model_out = '0;
    rst       = 1'b1;
    io_in     = '0;
    test_reset();
    test_first_word();
    test_second_word();
    test_glitch();
    test_back_to_back();
    test_reset_mid_settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
